imem_pipelined: RTL

//  Parametrised instruction memory for the fetch stage.
//  - Valid/ready request and response channels, 1..4 cycle read latency, whole-pipe backpressure.
//  - Flush for branch redirects.
//  - Byte-strobed write port for bootloader/debug program loading.
//  - Sits between the fetch unit and the instruction RAM array; replaces the fixed 1-cycle, always-valid memory.

---
 rtl/imem_pipelined.sv | 80 ++++++++
 1 files changed

// File: rtl/imem_pipelined.sv
// Instruction memory for the fetch stage: valid/ready request/response channels,
// 1..4 cycle read latency with whole-pipe backpressure, flush, byte-strobed write port.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 10
`endif

module imem_pipelined #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = `IMEM_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = 1,
  parameter              IMEM_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned LAST      = READ_LATENCY - 1;

  if (READ_LATENCY == 0 || READ_LATENCY > 4) begin : g_bad_latency
    $error("imem_pipelined: READ_LATENCY must be in 1..4");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("imem_pipelined: DATA_WIDTH must be a multiple of 8");
  end

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [READ_LATENCY-1:0] v;
  logic [DATA_WIDTH-1:0]   d   [READ_LATENCY];
  logic                    stall;
  logic                    advance;

  // Stall freezes the whole pipe, including the RAM read register; flush forces it to move.
  assign stall     = v[LAST] & ~rsp_ready;
  assign advance   = ~stall | flush;
  assign req_ready = advance;
  assign rsp_valid = v[LAST] & ~flush;
  assign rsp_data  = d[LAST];

  // Read pipeline: s0 is the synchronous RAM read, later stages only add latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        d[i] <= '0;
      end
    end else if (advance) begin
      v[0] <= req_valid;
      d[0] <= mem[req_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        v[i] <= v[i-1] & ~flush;
        d[i] <= d[i-1];
      end
    end
  end

  // Byte-strobed write; the read above samples the pre-write word (read-first).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_strb[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule
